// File: rtl/branch_target_unit.sv
// Branch target unit: next-PC + immediate target adder, a direct-mapped BTB
// with 2-bit saturating counters, and registered misprediction detection.
module branch_target_unit #(
    parameter int ADDR_W     = 8,
    parameter int IMM_W      = 8,
    parameter int DEPTH      = 4,
    parameter int SIGNED_IMM = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic [ADDR_W-1:0] resolve_next_pc,
    input  logic [IMM_W-1:0]  resolve_imm,
    input  logic              resolve_taken,
    input  logic              resolve_pred_taken,
    input  logic [ADDR_W-1:0] resolve_pred_target,
    output logic [ADDR_W-1:0] bt,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    function automatic logic [ADDR_W-1:0] ext_imm(input logic [IMM_W-1:0] imm);
        logic [ADDR_W-1:0] r;
        r = {ADDR_W{(SIGNED_IMM != 0) && imm[IMM_W-1]}};
        r[IMM_W-1:0] = imm;
        return r;
    endfunction

    function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            return (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
    endfunction

    logic              valid_q [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [ADDR_W-1:0] tgt_q   [DEPTH];
    logic [1:0]        ctr_q   [DEPTH];

    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [ADDR_W-1:0] pred_target_q, pred_target_d;
    logic [ADDR_W-1:0] bt_q, bt_d;
    logic              mispredict_q, mispredict_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;

    logic [IDX_W-1:0]  l_idx, r_idx;
    logic              l_hit, l_taken, r_hit;
    logic [ADDR_W-1:0] tgt;
    logic              btb_we;
    logic [ADDR_W-1:0] wr_tgt;
    logic [1:0]        wr_ctr;

    // Lookup/resolve decode and BTB write selection; array reads see pre-update state
    always_comb begin
        l_idx   = lookup_pc[IDX_W-1:0];
        l_hit   = valid_q[l_idx] && (tag_q[l_idx] == lookup_pc[ADDR_W-1:IDX_W]);
        l_taken = l_hit && ctr_q[l_idx][1];
        r_idx   = resolve_pc[IDX_W-1:0];
        r_hit   = valid_q[r_idx] && (tag_q[r_idx] == resolve_pc[ADDR_W-1:IDX_W]);
        tgt     = resolve_next_pc + ext_imm(resolve_imm);
        btb_we  = 1'b0;
        wr_tgt  = tgt_q[r_idx];
        wr_ctr  = ctr_q[r_idx];
        if (resolve_valid && r_hit) begin
            btb_we = 1'b1;
            wr_ctr = ctr_update(ctr_q[r_idx], resolve_taken);
            wr_tgt = resolve_taken ? tgt : tgt_q[r_idx];
        end else if (resolve_valid && resolve_taken) begin
            btb_we = 1'b1;
            wr_ctr = 2'b10;
            wr_tgt = tgt;
        end else begin
            btb_we = 1'b0;
        end
    end

    // Next-state for the registered prediction and resolve outputs
    always_comb begin
        pred_valid_d  = lookup_valid;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        bt_d          = bt_q;
        redirect_d    = redirect_q;
        mispredict_d  = 1'b0;
        if (lookup_valid) begin
            pred_taken_d  = l_taken;
            pred_target_d = l_taken ? tgt_q[l_idx] : lookup_pc + PC_INC;
        end else begin
            pred_taken_d  = pred_taken_q;
        end
        if (resolve_valid) begin
            bt_d         = tgt;
            redirect_d   = resolve_taken ? tgt : resolve_next_pc;
            mispredict_d = (resolve_pred_taken != resolve_taken) ||
                           (resolve_taken && (resolve_pred_target != tgt));
        end else begin
            mispredict_d = 1'b0;
        end
    end

    // BTB storage; reset only invalidates, payload fields are written with their valid bit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (btb_we) begin
            valid_q[r_idx] <= 1'b1;
            tag_q[r_idx]   <= resolve_pc[ADDR_W-1:IDX_W];
            tgt_q[r_idx]   <= wr_tgt;
            ctr_q[r_idx]   <= wr_ctr;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= {ADDR_W{1'b0}};
            bt_q          <= {ADDR_W{1'b0}};
            mispredict_q  <= 1'b0;
            redirect_q    <= {ADDR_W{1'b0}};
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            bt_q          <= bt_d;
            mispredict_q  <= mispredict_d;
            redirect_q    <= redirect_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign bt          = bt_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;

endmodule
